// File: rtl/serial_adder.sv
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial adder, one full-adder cell plus carry flop, LSB first.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_psum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;

    logic             w_s;
    logic             w_c;

    // Full-adder cell on the current LSB pair and the stored carry
    assign w_s = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                RUN: begin
                    r_carry <= w_c;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_psum  <= {w_s, r_psum[WIDTH-1:1]};
                    if (r_cnt == C_LAST) begin
                        // Final bit: publish the result straight from the cell
                        sum     <= {w_s, r_psum[WIDTH-1:1]};
                        cout    <= w_c;
                        r_state <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Directed scoreboard bench for serial_adder (WIDTH=8).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;

    logic [WIDTH:0]   sb[$];
    int               checks = 0;
    int               errors = 0;
    int               done_seen = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge, result popped on done
    task automatic tick();
        logic [WIDTH:0] exp;
        @(posedge clk);
        #1;
        chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
        if (done === 1'b1) begin
            done_seen++;
            chk("sb_empty_on_done", {31'd0, sb.size() == 0}, 32'd0);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("result", {23'd0, cout, sum}, {23'd0, exp});
            end
        end
    endtask

    task automatic drive(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic vc, input bit push);
        a   = va;
        b   = vb;
        cin = vc;
        if (push) sb.push_back({1'b0, va} + {1'b0, vb} + {{WIDTH{1'b0}}, vc});
    endtask

    task automatic wait_done(input string tag, input int lat);
        int n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40);
        chk(tag, n, lat);
    endtask

    task automatic add(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                       input logic vc, input string tag);
        drive(va, vb, vc, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(tag, WIDTH);
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] prev_sum;
        logic             prev_cout;
        int               dn;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Directed additions
        add(8'h00, 8'h00, 1'b0, "lat_zero");
        add(8'h0F, 8'h01, 1'b0, "lat_0f_01");
        add(8'hFF, 8'h01, 1'b0, "lat_ff_01");
        add(8'hFF, 8'hFF, 1'b1, "lat_ff_ff_c");
        add(8'hA5, 8'h5A, 1'b1, "lat_a5_5a_c");
        chk("sum_after_a5", {24'd0, sum}, 32'h00);
        chk("cout_after_a5", {31'd0, cout}, 32'd1);

        // Start during RUN must be ignored; sum holds prior result
        prev_sum  = sum;
        prev_cout = cout;
        drive(8'h12, 8'h34, 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        drive(8'hFF, 8'hFF, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("hold_sum", {24'd0, sum}, {24'd0, prev_sum});
        chk("hold_cout", {31'd0, cout}, {31'd0, prev_cout});
        wait_done("lat_ignore_start", WIDTH - 4);
        chk("sum_12_34", {24'd0, sum}, 32'h46);
        tick();
        chk("single_done", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, busy}, 32'd0);

        // Reset mid-RUN abandons the addition
        drive(8'h80, 8'h80, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        dn = done_seen;
        repeat (12) tick();
        chk("no_done_after_rst", dn, done_seen);
        add(8'h80, 8'h80, 1'b0, "lat_80_80");
        chk("cout_80_80", {31'd0, cout}, 32'd1);

        // Start held high: back-to-back accepts in the DONE cycle
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b1);
            tick();
            chk("b2b_busy", {31'd0, busy}, 32'd1);
            drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0);
            wait_done("b2b_latency", WIDTH);
        end
        start = 1'b0;
        tick();
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
